// File: rtl/module_counter.sv
// Free-running modulo counter with a run-time terminal value and a terminal-count pulse.
// tc is decoded from the count register and the live inputs, so it responds in the same cycle.
module module_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] max_count,
  output logic             tc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic             w_tc;
  logic [WIDTH-1:0] w_count_inc;

  // The >= comparison makes a count stranded above a lowered terminal wrap at once.
  assign w_tc        = enable & (r_count >= max_count) & ~rst;
  assign w_count_inc = r_count + {{(WIDTH-1){1'b0}}, 1'b1};

  // Count register: reset wins over enable and over the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {WIDTH{1'b0}};
    end else if (enable) begin
      if (w_tc) begin
        r_count <= {WIDTH{1'b0}};
      end else begin
        r_count <= w_count_inc;
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign tc    = w_tc;
  assign count = r_count;

endmodule

// File: tb/tb_module_counter.sv
// Scoreboard bench for module_counter: expectations are queued when inputs are driven
// and popped when the outputs are sampled after the falling edge.
module tb_module_counter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] max_count;
  logic             tc;
  logic [WIDTH-1:0] count;

  int               n_total = 0;
  int               n_bad   = 0;
  logic [WIDTH-1:0] m_count;
  logic [WIDTH:0]   sb_q[$];

  always #5 clk = ~clk;

  module_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .max_count(max_count),
    .tc       (tc),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, sample, compare, advance the model.
  task automatic step(input string tag, input logic r, input logic en, input logic [WIDTH-1:0] mc,
                      output logic o_tc, output logic [WIDTH-1:0] o_cnt);
    logic           exp_tc;
    logic [WIDTH:0] e;
    @(negedge clk);
    rst       = r;
    enable    = en;
    max_count = mc;
    exp_tc    = en && !r && (m_count >= mc);
    sb_q.push_back({exp_tc, m_count});
    #1;
    o_tc  = tc;
    o_cnt = count;
    e     = sb_q.pop_front();
    chk($sformatf("%s.tc", tag), 32'(tc), 32'(e[WIDTH]));
    chk($sformatf("%s.count", tag), 32'(count), 32'(e[WIDTH-1:0]));
    if (r) m_count = '0;
    else if (en) m_count = exp_tc ? '0 : m_count + 8'd1;
  endtask

  initial begin
    logic             t;
    logic [WIDTH-1:0] c;
    int               pulses[$];

    rst = 1'b1; enable = 1'b0; max_count = '0;
    @(posedge clk);
    m_count = '0;

    // reset holds tc low even with enable high and count >= max_count
    step("rst_hold", 1'b1, 1'b1, 8'd0, t, c);
    chk("rst_tc", 32'(t), 32'd0);
    chk("rst_cnt", 32'(c), 32'd0);

    // max_count=1: alternating pattern
    for (int i = 0; i < 6; i++) begin
      step("p1", 1'b0, 1'b1, 8'd1, t, c);
      chk("p1_tc_pat", 32'(t), 32'(i % 2));
      chk("p1_cnt_pat", 32'(c), 32'(i % 2));
    end

    // max_count=127: pulses at 127, 255, 383
    step("rst", 1'b1, 1'b0, 8'd127, t, c);
    for (int i = 0; i < 400; i++) begin
      step("p127", 1'b0, 1'b1, 8'd127, t, c);
      if (t) pulses.push_back(i);
    end
    chk("p127_npulse", 32'(pulses.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("p127_at", (k < pulses.size()) ? 32'(pulses[k]) : 32'hFFFF_FFFF, 32'(127 * (k + 1) + k));

    // enable low for 3 cycles at count 3
    step("rst", 1'b1, 1'b0, 8'd5, t, c);
    for (int i = 0; i < 3; i++) step("en_run", 1'b0, 1'b1, 8'd5, t, c);
    for (int i = 0; i < 3; i++) begin
      step("en_off", 1'b0, 1'b0, 8'd5, t, c);
      chk("hold_cnt", 32'(c), 32'd3);
      chk("hold_tc", 32'(t), 32'd0);
    end
    step("en_res", 1'b0, 1'b1, 8'd5, t, c);
    step("en_res", 1'b0, 1'b1, 8'd5, t, c);
    step("en_res", 1'b0, 1'b1, 8'd5, t, c);
    chk("res_cnt5", 32'(c), 32'd5);
    chk("res_tc5", 32'(t), 32'd1);

    // lower max_count below current count
    step("rst", 1'b1, 1'b0, 8'd10, t, c);
    for (int i = 0; i < 8; i++) step("lo_run", 1'b0, 1'b1, 8'd10, t, c);
    step("lo_drop", 1'b0, 1'b1, 8'd4, t, c);
    chk("lo_cnt8", 32'(c), 32'd8);
    chk("lo_tc8", 32'(t), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step("lo_after", 1'b0, 1'b1, 8'd4, t, c);
      chk("lo_cnt_k", 32'(c), 32'(k));
      chk("lo_tc_k", 32'(t), 32'(k == 4));
    end

    // max_count=0
    step("rst", 1'b1, 1'b0, 8'd0, t, c);
    for (int i = 0; i < 4; i++) begin
      step("z", 1'b0, 1'b1, 8'd0, t, c);
      chk("z_tc", 32'(t), 32'd1);
      chk("z_cnt", 32'(c), 32'd0);
    end
    step("z_off", 1'b0, 1'b0, 8'd0, t, c);
    chk("z_off_tc", 32'(t), 32'd0);

    // one-cycle reset pulse at count 50
    step("rst", 1'b1, 1'b0, 8'd127, t, c);
    for (int i = 0; i < 50; i++) step("pr_run", 1'b0, 1'b1, 8'd127, t, c);
    step("pr_pulse", 1'b1, 1'b1, 8'd127, t, c);
    chk("pr_tc", 32'(t), 32'd0);
    chk("pr_cnt50", 32'(c), 32'd50);
    pulses.delete();
    for (int i = 0; i < 130; i++) begin
      step("pr_after", 1'b0, 1'b1, 8'd127, t, c);
      if (i == 0) chk("pr_cnt0", 32'(c), 32'd0);
      if (t) pulses.push_back(i);
    end
    chk("pr_first", (pulses.size() > 0) ? 32'(pulses[0]) : 32'hFFFF_FFFF, 32'd127);

    // full-range terminal value
    step("rst", 1'b1, 1'b0, 8'd255, t, c);
    pulses.delete();
    for (int i = 0; i < 257; i++) begin
      step("full", 1'b0, 1'b1, 8'd255, t, c);
      if (t) pulses.push_back(i);
      if (i == 256) chk("full_wrap", 32'(c), 32'd0);
    end
    chk("full_npulse", 32'(pulses.size()), 32'd1);
    chk("full_at", (pulses.size() > 0) ? 32'(pulses[0]) : 32'hFFFF_FFFF, 32'd255);

    // raise max_count mid-sequence
    step("rst", 1'b1, 1'b0, 8'd3, t, c);
    for (int i = 0; i < 3; i++) step("up_run", 1'b0, 1'b1, 8'd3, t, c);
    for (int k = 3; k <= 7; k++) begin
      step("up_raise", 1'b0, 1'b1, 8'd6, t, c);
      chk("up_cnt", 32'(c), 32'(k == 7 ? 0 : k));
      chk("up_tc", 32'(t), 32'(k == 6));
    end

    // random mix
    for (int i = 0; i < 300; i++)
      step("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           WIDTH'($urandom_range(0, 15)), t, c);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/module_counter.md
MODULE_COUNTER -- requirements
Module: module_counter

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the count register and of max_count.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates occur on this edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high; clock clk.
REQ-004 Port: enable  input  1  count enable; when low the counter holds its value.
REQ-005 Port: max_count  input  WIDTH  terminal value; the count sequence is 0..max_count, giving a period of max_count+1 enabled cycles.
REQ-006 Port: tc  output  1  terminal-count pulse, high for the cycle in which the count reaches its terminal value.
REQ-007 Port: count  output  WIDTH  current count value, direct from the count register; may be left unconnected.

Function
REQ-008 The block SHALL hold one WIDTH-bit unsigned count register, updated only on rising clk.
REQ-009 tc SHALL be combinational from registered state: tc = enable AND (count >= max_count) AND NOT rst.
REQ-010 When enable=1 and tc=1, the count SHALL load 0 on the next edge (wrap).
REQ-011 When enable=1 and tc=0, the count SHALL increment by 1 modulo 2^WIDTH on the next edge.
REQ-012 When enable=0, the count SHALL hold its value and tc SHALL be 0.
REQ-013 With enable held high after reset, tc SHALL pulse for one cycle every max_count+1 cycles, first at cycle max_count after reset release (cycle 0 = first edge with rst low).
REQ-014 max_count=0: tc SHALL be high on every enabled cycle and the count SHALL stay 0.
REQ-015 max_count=2^WIDTH-1: the period SHALL be 2^WIDTH cycles with no overflow side effects.
REQ-016 If max_count is lowered below the current count mid-sequence, tc SHALL assert on the next enabled cycle (>= comparison) and the count SHALL wrap to 0; no long wrap through 2^WIDTH is allowed.
REQ-017 If max_count is raised mid-sequence, counting SHALL continue from the current value to the new terminal value.
REQ-018 max_count SHALL be sampled combinationally every cycle; no internal copy is kept.
REQ-019 No latency beyond one clock from input change to count change; tc responds in the same cycle to count, enable and max_count.

Reset
REQ-020 While rst=1 at a rising edge, the count SHALL load 0, regardless of enable.
REQ-021 While rst=1, tc SHALL be 0.
REQ-022 Reset asserted mid-sequence SHALL abort the sequence; counting restarts from 0 on the first edge with rst low.
REQ-023 rst SHALL take priority over enable and over the wrap condition.
REQ-024 Reset SHALL be usable as a one-cycle synchronous restart (a pulse) by surrounding logic, with the same effect as a long reset.

Verification
REQ-025 WIDTH=8, max_count=1, enable=1, release rst -> tc pattern 0,1,0,1,... (period 2), count 0,1,0,1.
REQ-026 max_count=127, enable=1 -> tc high exactly at cycles 127, 255, 383 after release; count wraps 127->0.
REQ-027 max_count=5, enable toggled low for 3 cycles at count=3 -> count holds at 3, tc stays 0, then resumes; tc at count 5.
REQ-028 max_count=10, count=8, then max_count set to 4 -> tc high that cycle, count 0 next edge; next tc after 4 further cycles.
REQ-029 max_count=0 -> tc constantly 1 with enable=1, count constantly 0; enable=0 -> tc 0.
REQ-030 One-cycle rst pulse at count=50 (max_count=127) -> tc 0 during the pulse, count 0 next edge, next tc 127 cycles after release.
